// File: rtl/push_debouncer.sv
// Push-button synchroniser and debouncer: press/release accepted DEBOUNCE_CYCLES+2 edges after first sampling, no backpressure.
// Optional auto-repeat of push_pulse while held is enabled by defining PUSH_REPEAT_EN.
module push_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    output logic push_clean,
    output logic push_pulse,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_TGT  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2**CNT_W) - 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("push_debouncer: parameter out of range");
    end

    logic             sync1_q, sync2_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             press_accept;
    logic             rep_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= push;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
        end
    end

    // The counter only advances below the target, so it saturates instead of wrapping.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clean_d      = clean_q;
        press_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_TGT) begin
                    state_d      = PRESSED;
                    cnt_d        = '0;
                    clean_d      = 1'b1;
                    press_accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_TGT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d  = (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
        pulse_d = press_accept || (rep_fire && !pulse_q);
    end

`ifdef PUSH_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_DLY = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] REP_PER = CNT_W'(REPEAT_PERIOD);

    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
    logic             rep_first_q, rep_first_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end

    // Only counts while PRESSED is held across the edge; any entry into PRESSED restarts the delay.
    always_comb begin
        rep_cnt_d   = '0;
        rep_first_d = 1'b1;
        rep_fire    = 1'b0;
        rep_inc     = rep_cnt_q + CNT_ONE;
        if (state_q == PRESSED && state_d == PRESSED) begin
            rep_first_d = rep_first_q;
            if (rep_inc == (rep_first_q ? REP_DLY : REP_PER)) begin
                rep_fire    = 1'b1;
                rep_first_d = 1'b0;
            end else if (rep_cnt_q != '1) begin
                rep_cnt_d = rep_inc;
            end else begin
                rep_cnt_d = rep_cnt_q;
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign push_clean = clean_q;
    assign push_pulse = pulse_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_push_debouncer.sv
// Bench for push_debouncer: directed scenarios plus random bouncing, checked against a run-length model.
module tb_push_debouncer;
    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 4;
    // Tick 1 is the first edge sampling a new level, so acceptance lands on tick D+3.
    localparam int ACCEPT_TICK = D + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic push = 1'b0;
    logic push_clean, push_pulse, busy;

    always #5 clk = ~clk;

    push_debouncer #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(16),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .push_clean(push_clean),
        .push_pulse(push_pulse),
        .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic hist[$];
    logic m_clean, m_pulse, m_busy;
    int   m_run, m_since;

    int   tick_no, pulse_cnt, first_pulse_tick, last_pulse_tick;
    int   first_clean_fall, busy_ticks, clean_rises;
    logic prev_clean;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_clean = 1'b0;
        m_pulse = 1'b0;
        m_busy  = 1'b0;
        m_run   = 0;
        m_since = 0;
        prev_clean = 1'b0;
    endtask

    // A level is accepted once the value seen two samples late has differed from the clean level for D+1 edges.
    task automatic model_edge(input logic p);
        logic seen, old_clean;
        int   old_run;
        hist.push_back(p);
        if (hist.size() > 3) void'(hist.pop_front());
        seen = (hist.size() == 3) ? hist[0] : 1'b0;
        old_clean = m_clean;
        old_run   = m_run;
        m_pulse   = 1'b0;
        if (seen != m_clean) m_run++;
        else m_run = 0;
        if (m_run >= D + 1) begin
            m_clean = ~m_clean;
            m_run   = 0;
            if (m_clean) m_pulse = 1'b1;
        end
        m_busy = (m_run > 0);
`ifdef PUSH_REPEAT_EN
        if (m_clean && m_run == 0 && old_clean && old_run == 0) begin
            m_since++;
            if (m_since == RD || (m_since > RD && (m_since - RD) % RP == 0)) m_pulse = 1'b1;
        end else begin
            m_since = 0;
        end
`else
        if (old_clean && old_run < 0) m_since = 0;
`endif
    endtask

    task automatic clr();
        tick_no          = 0;
        pulse_cnt        = 0;
        first_pulse_tick = -1;
        last_pulse_tick  = -1;
        first_clean_fall = -1;
        busy_ticks       = 0;
        clean_rises      = 0;
    endtask

    task automatic tick(input logic p);
        push = p;
        @(posedge clk);
        model_edge(p);
        tick_no++;
        #1;
        chk("push_clean", push_clean, m_clean);
        chk("push_pulse", push_pulse, m_pulse);
        chk("busy", busy, m_busy);
        if (push_pulse) begin
            pulse_cnt++;
            if (first_pulse_tick < 0) first_pulse_tick = tick_no;
            last_pulse_tick = tick_no;
        end
        if (busy) busy_ticks++;
        if (push_clean && !prev_clean) clean_rises++;
        if (!push_clean && prev_clean && first_clean_fall < 0) first_clean_fall = tick_no;
        prev_clean = push_clean;
    endtask

    initial begin
        logic lvl;
        int   len;

        // Reset held with the button pressed
        model_reset();
        clr();
        rst_n = 1'b0;
        push  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clean", push_clean, 1'b0);
        chk("rst_pulse", push_pulse, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick(1'b1);
        chk_int("rst_release_pulse_tick", first_pulse_tick, ACCEPT_TICK);
        chk_int("rst_release_pulse_cnt", pulse_cnt, 1);
        chk("rst_release_clean", push_clean, 1'b1);

        // Release: clean falls after qualification, no pulse, busy for D edges
        clr();
        for (int i = 0; i < 10; i++) tick(1'b0);
        chk_int("release_fall_tick", first_clean_fall, ACCEPT_TICK);
        chk_int("release_pulse_cnt", pulse_cnt, 0);
        chk_int("release_busy_ticks", busy_ticks, D);

        // Clean press
        clr();
        for (int i = 0; i < 12; i++) tick(1'b1);
        chk_int("press_pulse_tick", first_pulse_tick, ACCEPT_TICK);
        chk_int("press_pulse_cnt", pulse_cnt, 1);
        chk_int("press_busy_ticks", busy_ticks, D);
        clr();
        for (int i = 0; i < 10; i++) tick(1'b0);
        chk_int("press_release_fall", first_clean_fall, ACCEPT_TICK);
        chk_int("press_release_pulses", pulse_cnt, 0);

        // Bounce: 2-cycle toggles, then held from tick 13
        clr();
        for (int i = 0; i < 12; i++) tick(((i / 2) % 2) == 0);
        chk_int("bounce_no_clean_change", clean_rises, 0);
        for (int i = 0; i < 12; i++) tick(1'b1);
        chk_int("bounce_pulse_tick", first_pulse_tick, 13 + D + 2);
        chk_int("bounce_pulse_cnt", pulse_cnt, 1);
        for (int i = 0; i < 10; i++) tick(1'b0);
        chk("bounce_released", push_clean, 1'b0);

        // Glitch shorter than the debounce window
        clr();
        for (int i = 0; i < 3; i++) tick(1'b1);
        for (int i = 0; i < 10; i++) tick(1'b0);
        chk_int("glitch_pulse_cnt", pulse_cnt, 0);
        chk_int("glitch_clean_rises", clean_rises, 0);
        chk_int("glitch_busy_seen", (busy_ticks > 0) ? 1 : 0, 1);
        chk("glitch_busy_end", busy, 1'b0);

        // Long hold: auto-repeat when enabled
        clr();
        for (int i = 0; i < ACCEPT_TICK + 30; i++) tick(1'b1);
`ifdef PUSH_REPEAT_EN
        chk_int("repeat_pulse_cnt", pulse_cnt, 7);
        chk_int("repeat_last_tick", last_pulse_tick, ACCEPT_TICK + 28);
`else
        chk_int("repeat_pulse_cnt", pulse_cnt, 1);
        chk_int("repeat_last_tick", last_pulse_tick, ACCEPT_TICK);
`endif

        // Asynchronous reset while pressed, then requalified press
        rst_n = 1'b0;
        #2;
        chk("midrst_clean", push_clean, 1'b0);
        chk("midrst_pulse", push_pulse, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        for (int i = 0; i < 10; i++) tick(1'b1);
        chk_int("midrst_pulse_tick", first_pulse_tick, ACCEPT_TICK);
        chk_int("midrst_pulse_cnt", pulse_cnt, 1);

        // Random bouncing against the model
        for (int r = 0; r < 300; r++) begin
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 10));
            for (int i = 0; i < len; i++) tick(lvl);
        end
        for (int i = 0; i < 12; i++) tick(1'b0);
        chk("final_clean", push_clean, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
